// File: rtl/mul_pkg.sv
// Purpose: shared op codes, FSM state encoding and op-decode helpers for the
//          multi-cycle multiply/accumulate unit.
// Contents: OP_* op-code localparams, state_e enum, is_signed/is_acc/is_sub.
package mul_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
  localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
  localparam logic [OP_W-1:0] OP_MADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_MADDU = 3'b011;
  localparam logic [OP_W-1:0] OP_MSUB  = 3'b100;
  localparam logic [OP_W-1:0] OP_MSUBU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Signed variants take absolute values and negate the product at the end.
  function automatic logic is_signed(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Reserved codes fall through every helper and so behave as MULTU.
  function automatic logic is_acc(input logic [OP_W-1:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub(input logic [OP_W-1:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mul_pp_row.sv
// Purpose: one row of partial products: WIDTH-bit multiplicand times a
//          LIMB_W-bit slice of the multiplier, shifted to the row's weight.
// Ports:
//   a_i     WIDTH       multiplicand (already absolute value where needed)
//   limb_i  LIMB_W      multiplier slice for this row
//   row_i   RW          row index; shift = row_i * LIMB_W
//   pp_o    2*WIDTH     shifted partial product
module mul_pp_row #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LIMB_W = 16,
  parameter int unsigned RW     = 2
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [LIMB_W-1:0]  limb_i,
  input  logic [RW-1:0]      row_i,
  output logic [2*WIDTH-1:0] pp_o
);

  localparam int unsigned DW = 2 * WIDTH;

  logic [DW-1:0] prod_c;

  // Product fits in WIDTH+LIMB_W bits, so no truncation before the shift.
  always_comb begin
    prod_c = DW'(a_i) * DW'(limb_i);
    pp_o   = prod_c << (32'(row_i) * LIMB_W);
  end

endmodule

// File: rtl/mul_multicycle.sv
// Purpose: multi-cycle integer multiply / multiply-accumulate for the EX stage.
//          One LIMB_W row of partial products per cycle, then sign fix-up and
//          optional HI/LO accumulate. Holds the pipeline via mul_stall.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start_i, op_i        request and op code (accepted only when idle)
//   opdata1_i/opdata2_i  multiplicand / multiplier
//   hilo_i               {HI,LO} accumulate source
//   flush_i              cancel in-flight op (wins over start and completion)
//   result_o             registered 2*WIDTH result, held until next completion
//   ready_o              one-cycle pulse when result_o is updated
//   mul_stall            high while an accepted op is in progress
module mul_multicycle
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LIMB_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic [OP_W-1:0]      op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  input  logic                 flush_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 mul_stall
);

  localparam int unsigned NROW = WIDTH / LIMB_W;
  localparam int unsigned RW   = $clog2(NROW) + 1;
  localparam int unsigned DW   = 2 * WIDTH;

  state_e          state_q;
  logic [OP_W-1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            neg_q;
  logic [DW-1:0]   hilo_q, acc_q, result_q;
  logic [RW-1:0]   row_q;
  logic            ready_q, stall_q;

  logic [WIDTH-1:0]  a_abs_c, b_abs_c;
  logic              neg_c;
  logic [LIMB_W-1:0] limb_c;
  logic [DW-1:0]     pp_c, acc_d, p_c, fix_d;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is exact as unsigned.
  always_comb begin
    a_abs_c = (is_signed(op_i) && opdata1_i[WIDTH-1]) ? WIDTH'(-opdata1_i) : opdata1_i;
    b_abs_c = (is_signed(op_i) && opdata2_i[WIDTH-1]) ? WIDTH'(-opdata2_i) : opdata2_i;
    neg_c   = is_signed(op_i) && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
  end

  // Current row's multiplier slice.
  always_comb begin
    limb_c = LIMB_W'(b_q >> (32'(row_q) * LIMB_W));
  end

  mul_pp_row #(
    .WIDTH  (WIDTH),
    .LIMB_W (LIMB_W),
    .RW     (RW)
  ) u_pp_row (
    .a_i    (a_q),
    .limb_i (limb_c),
    .row_i  (row_q),
    .pp_o   (pp_c)
  );

  // Accumulate, sign fix-up and HI/LO combine; all arithmetic wraps mod 2^DW.
  always_comb begin
    acc_d = acc_q + pp_c;
    p_c   = neg_q ? DW'(-acc_q) : acc_q;
    fix_d = p_c;
    if (is_acc(op_q)) begin
      fix_d = is_sub(op_q) ? (hilo_q - p_c) : (hilo_q + p_c);
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      hilo_q   <= '0;
      acc_q    <= '0;
      row_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
        stall_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              op_q    <= op_i;
              a_q     <= a_abs_c;
              b_q     <= b_abs_c;
              neg_q   <= neg_c;
              hilo_q  <= hilo_i;
              acc_q   <= '0;
              row_q   <= '0;
              stall_q <= 1'b1;
              state_q <= ST_MUL;
            end
          end
          ST_MUL: begin
            acc_q <= acc_d;
            row_q <= row_q + RW'(1);
            if (row_q == RW'(NROW - 1)) begin
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            result_q <= fix_d;
            ready_q  <= 1'b1;
            stall_q  <= 1'b0;
            state_q  <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign result_o  = result_q;
  assign ready_o   = ready_q;
  assign mul_stall = stall_q;

endmodule

// File: tb/tb_mul_multicycle.sv
// Purpose: directed self-checking bench for mul_multicycle (WIDTH=32, LIMB_W=16),
//          plus a short run of random ops against a plain 64-bit arithmetic model.
module tb_mul_multicycle;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LIMB_W = 16;
  localparam int LAT = WIDTH / LIMB_W + 1;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] hilo_i;
  logic        flush_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        mul_stall;

  int checks = 0;
  int errors = 0;

  mul_multicycle #(.WIDTH(WIDTH), .LIMB_W(LIMB_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start_i),
    .op_i      (op_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .hilo_i    (hilo_i),
    .flush_i   (flush_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .mul_stall (mul_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Present a request during the current cycle; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h);
    start_i   = 1'b1;
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    hilo_i    = h;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready_o !== 1'b1 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic watch_no_ready(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) seen = 1'b1;
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] h);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    if (op == 3'd0 || op == 3'd2 || op == 3'd4) p = 64'(sa * sb);
    else p = {32'h0, a} * {32'h0, b};
    case (op)
      3'd2, 3'd3: return h + p;
      3'd4, 3'd5: return h - p;
      default:    return p;
    endcase
  endfunction

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] h, input logic [63:0] exp);
    int c;
    issue(op, a, b, h);
    chk({tag, "_stall_hi"}, 64'(mul_stall), 64'd1);
    wait_ready(c);
    chk({tag, "_lat"}, 64'(c), 64'(LAT));
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_stall_lo"}, 64'(mul_stall), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_ready_fall"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    logic [63:0] prev;
    logic        seen;
    int          c;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] rh;

    resetn = 1'b0; start_i = 1'b0; op_i = '0; opdata1_i = '0; opdata2_i = '0;
    hilo_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result_o, 64'h0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_stall", 64'(mul_stall), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run("mult_m1m1",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'h0000000000000001);
    run("multu_m1m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFE00000001);
    run("mult_min2",  3'b000, 32'h80000000, 32'h80000000, 64'h0, 64'h4000000000000000);
    run("mult_minx1", 3'b000, 32'h80000000, 32'h00000001, 64'h0, 64'hFFFFFFFF80000000);
    run("madd",       3'b010, 32'h00000003, 32'hFFFFFFFE, 64'h10, 64'h000000000000000A);
    run("msubu",      3'b101, 32'h00000001, 32'h00000001, 64'h0, 64'hFFFFFFFFFFFFFFFF);
    run("msub",       3'b100, 32'hFFFFFFFD, 32'h00000005, 64'd100, 64'd115);
    run("maddu_wrap", 3'b011, 32'h00000001, 32'h00000002, 64'hFFFFFFFFFFFFFFFF, 64'h1);
    run("rsvd110",    3'b110, 32'hFFFFFFFF, 32'h00000002, 64'h55, 64'h00000001FFFFFFFE);
    run("rsvd111",    3'b111, 32'h80000000, 32'hFFFFFFFF, 64'h55, 64'h7FFFFFFF80000000);

    // Flush one cycle after accept.
    prev = result_o;
    issue(3'b001, 32'd7, 32'd6, 64'h0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_stall", 64'(mul_stall), 64'd0);
    chk("flush_ready", 64'(ready_o), 64'd0);
    watch_no_ready(6, seen);
    chk("flush_no_ready", 64'(seen), 64'd0);
    chk("flush_result", result_o, prev);

    // Flush on the completion edge wins over the result write.
    issue(3'b001, 32'd9, 32'd9, 64'h0);
    repeat (LAT - 1) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flushfix_ready", 64'(ready_o), 64'd0);
    chk("flushfix_stall", 64'(mul_stall), 64'd0);
    chk("flushfix_result", result_o, prev);

    // Flush together with start: request is not accepted.
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b001; opdata1_i = 32'd3; opdata2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flushstart_stall", 64'(mul_stall), 64'd0);
    watch_no_ready(5, seen);
    chk("flushstart_no_ready", 64'(seen), 64'd0);

    // Changing start/op/operands mid-op has no effect.
    issue(3'b001, 32'd2, 32'd3, 64'h0);
    start_i = 1'b1; op_i = 3'b000; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd5; hilo_i = 64'h99;
    wait_ready(c);
    start_i = 1'b0;
    chk("midop_lat", 64'(c), 64'(LAT));
    chk("midop_res", result_o, 64'd6);
    @(posedge clk); #1;
    chk("midop_idle", 64'(mul_stall), 64'd0);

    // Back-to-back: second request issued in the ready cycle.
    issue(3'b000, 32'd5, 32'hFFFFFFFF, 64'h0);
    wait_ready(c);
    chk("b2b_first_lat", 64'(c), 64'(LAT));
    chk("b2b_first_res", result_o, 64'hFFFFFFFFFFFFFFFB);
    issue(3'b001, 32'd7, 32'd6, 64'h0);
    chk("b2b_stall", 64'(mul_stall), 64'd1);
    wait_ready(c);
    chk("b2b_second_lat", 64'(c), 64'(LAT));
    chk("b2b_second_res", result_o, 64'd42);
    @(posedge clk); #1;

    // Reset mid-op clears all outputs and aborts the op.
    issue(3'b001, 32'd11, 32'd13, 64'h0);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("midrst_result", result_o, 64'h0);
    chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_stall", 64'(mul_stall), 64'd0);
    watch_no_ready(5, seen);
    chk("midrst_no_ready", 64'(seen), 64'd0);

    // Random ops against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      rh  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = (i % 2 == 0) ? 32'h80000000 : 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) rb = (i % 3 == 0) ? 32'h80000000 : 32'h00000000;
      run("rand", rop, ra, rb, rh, model(rop, ra, rb, rh));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
